// File: rtl/l2_vec_seq_if.sv
// Sample-in / result-out handshake bundle for the L2-norm vector sequencer.
interface l2_vec_seq_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 20,
   parameter int unsigned CNT_W  = 3
);
   logic [DATA_W-1:0] a;
   logic              valid_in;
   logic              ready_in;
   logic              flush;
   logic [ACC_W-1:0]  f;
   logic              valid_out;
   logic              ready_out;
   logic              overflow;
   logic [CNT_W-1:0]  count;

   modport master (
      output a, valid_in, flush, ready_out,
      input  ready_in, f, valid_out, overflow, count
   );

   modport slave (
      input  a, valid_in, flush, ready_out,
      output ready_in, f, valid_out, overflow, count
   );
endinterface

// File: rtl/l2_vec_seq.sv
// Frames unsigned samples into VEC_LEN vectors and emits one saturated
// sum of squares per vector through a ready/valid result handshake.
module l2_vec_seq #(
   parameter int unsigned VEC_LEN = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ACC_W   = 20,
   parameter int unsigned CNT_W   = $clog2(VEC_LEN + 1)
) (
   input  logic         clk,
   input  logic         reset,
   l2_vec_seq_if.slave  bus
);
   localparam int unsigned SQ_W  = 2 * DATA_W;
   localparam int unsigned SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

   typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

   state_t            r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_f;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_ready_in;
   logic              r_valid_out;

   logic [SQ_W-1:0]   w_sq;
   logic [SUM_W-1:0]  w_sum;
   logic              w_sat;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic              w_last;

   // Saturating square-accumulate; any carry above ACC_W bits clamps to all ones
   assign w_sq      = SQ_W'(bus.a) * SQ_W'(bus.a);
   assign w_sum     = SUM_W'(r_acc) + SUM_W'(w_sq);
   assign w_sat     = |w_sum[SUM_W-1:ACC_W];
   assign w_acc_nxt = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign w_last    = (r_cnt == CNT_W'(VEC_LEN - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_f         <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_ready_in  <= 1'b1;
         r_valid_out <= 1'b0;
      end else if (bus.flush) begin
         // Flush wins over a same-cycle accept or result handshake; f is kept
         r_state     <= ST_ACCUM;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_ready_in  <= 1'b1;
         r_valid_out <= 1'b0;
      end else if (r_state == ST_ACCUM) begin
         if (bus.valid_in) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_f         <= w_acc_nxt;
               r_state     <= ST_DONE;
               r_ready_in  <= 1'b0;
               r_valid_out <= 1'b1;
            end
         end
      end else begin
         if (bus.ready_out) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_ready_in  <= 1'b1;
            r_valid_out <= 1'b0;
         end
      end
   end

   assign bus.ready_in  = r_ready_in;
   assign bus.valid_out = r_valid_out;
   assign bus.f         = r_f;
   assign bus.overflow  = r_ovf;
   assign bus.count     = r_cnt;
endmodule

// File: tb/tb_l2_vec_seq.sv
// Directed vector bench for l2_vec_seq: VEC_LEN=4 table plus a VEC_LEN=20 overflow run.
module tb_l2_vec_seq;
   logic clk = 1'b0;
   logic rst4;
   logic rst20;

   always #5 clk = ~clk;

   l2_vec_seq_if #(.DATA_W(8), .ACC_W(20), .CNT_W(3)) bus4 ();
   l2_vec_seq_if #(.DATA_W(8), .ACC_W(20), .CNT_W(5)) bus20 ();

   l2_vec_seq #(.VEC_LEN(4), .DATA_W(8), .ACC_W(20), .CNT_W(3)) u_dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4.slave)
   );

   l2_vec_seq #(.VEC_LEN(20), .DATA_W(8), .ACC_W(20), .CNT_W(5)) u_dut20 (
      .clk   (clk),
      .reset (rst20),
      .bus   (bus20.slave)
   );

   typedef struct {
      logic        rst;
      logic        vin;
      logic [7:0]  a;
      logic        fl;
      logic        ro;
      logic        e_rdy;
      logic        e_vo;
      logic [19:0] e_f;
      logic        e_ovf;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic rst, input logic vin, input logic [7:0] a,
                               input logic fl, input logic ro, input logic e_rdy,
                               input logic e_vo, input logic [19:0] e_f,
                               input logic e_ovf, input logic [2:0] e_cnt);
      vec_t v;
      v.rst = rst; v.vin = vin; v.a = a; v.fl = fl; v.ro = ro;
      v.e_rdy = e_rdy; v.e_vo = e_vo; v.e_f = e_f; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row=%0d actual=%0h expected=%0h", nm, row, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      logic [19:0] ef;
      logic        eovf;

      rst4 = 1'b1; rst20 = 1'b1;
      bus4.a = '0;  bus4.valid_in = 1'b0;  bus4.flush = 1'b0;  bus4.ready_out = 1'b0;
      bus20.a = '0; bus20.valid_in = 1'b0; bus20.flush = 1'b0; bus20.ready_out = 1'b0;

      // rst vin a fl ro | rdy vo f ovf cnt
      vq.push_back(mk(1,0,  0,0,0, 1,0,20'h00000,0,0));
      // 1,2,3,4 back to back
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h00000,0,1));
      vq.push_back(mk(0,1,  2,0,1, 1,0,20'h00000,0,2));
      vq.push_back(mk(0,1,  3,0,1, 1,0,20'h00000,0,3));
      vq.push_back(mk(0,1,  4,0,1, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h0001E,0,0));
      // 255 x4 then 1 x4
      vq.push_back(mk(0,1,255,0,1, 1,0,20'h0001E,0,1));
      vq.push_back(mk(0,1,255,0,1, 1,0,20'h0001E,0,2));
      vq.push_back(mk(0,1,255,0,1, 1,0,20'h0001E,0,3));
      vq.push_back(mk(0,1,255,0,1, 0,1,20'h3F804,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h3F804,0,0));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h3F804,0,1));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h3F804,0,2));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h3F804,0,3));
      vq.push_back(mk(0,1,  1,0,1, 0,1,20'h00004,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h00004,0,0));
      // 1,_,2,_,_,3,4 with gaps
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h00004,0,1));
      vq.push_back(mk(0,0, 77,0,1, 1,0,20'h00004,0,1));
      vq.push_back(mk(0,1,  2,0,1, 1,0,20'h00004,0,2));
      vq.push_back(mk(0,0, 88,0,1, 1,0,20'h00004,0,2));
      vq.push_back(mk(0,0, 99,0,1, 1,0,20'h00004,0,2));
      vq.push_back(mk(0,1,  3,0,1, 1,0,20'h00004,0,3));
      vq.push_back(mk(0,1,  4,0,1, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h0001E,0,0));
      // back-pressure with a=9 pushed while result is held
      vq.push_back(mk(0,1,  1,0,0, 1,0,20'h0001E,0,1));
      vq.push_back(mk(0,1,  2,0,0, 1,0,20'h0001E,0,2));
      vq.push_back(mk(0,1,  3,0,0, 1,0,20'h0001E,0,3));
      vq.push_back(mk(0,1,  4,0,0, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,1,  9,0,0, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,1,  9,0,0, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,1,  9,0,0, 0,1,20'h0001E,0,4));
      vq.push_back(mk(0,1,  9,0,1, 1,0,20'h0001E,0,0));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h0001E,0,1));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h0001E,0,2));
      vq.push_back(mk(0,1,  1,0,1, 1,0,20'h0001E,0,3));
      vq.push_back(mk(0,1,  1,0,1, 0,1,20'h00004,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h00004,0,0));
      // flush with a same-cycle sample
      vq.push_back(mk(0,1,  7,0,1, 1,0,20'h00004,0,1));
      vq.push_back(mk(0,1,  7,0,1, 1,0,20'h00004,0,2));
      vq.push_back(mk(0,1,  7,1,1, 1,0,20'h00004,0,0));
      vq.push_back(mk(0,1,  5,0,1, 1,0,20'h00004,0,1));
      vq.push_back(mk(0,1,  5,0,1, 1,0,20'h00004,0,2));
      vq.push_back(mk(0,1,  5,0,1, 1,0,20'h00004,0,3));
      vq.push_back(mk(0,1,  5,0,1, 0,1,20'h00064,0,4));
      vq.push_back(mk(0,0,  0,0,1, 1,0,20'h00064,0,0));
      // reset with a same-cycle sample, then flush while the result is pending
      vq.push_back(mk(0,1,  7,0,1, 1,0,20'h00064,0,1));
      vq.push_back(mk(0,1,  7,0,1, 1,0,20'h00064,0,2));
      vq.push_back(mk(1,1,  7,0,1, 1,0,20'h00000,0,0));
      vq.push_back(mk(0,1,  5,0,0, 1,0,20'h00000,0,1));
      vq.push_back(mk(0,1,  5,0,0, 1,0,20'h00000,0,2));
      vq.push_back(mk(0,1,  5,0,0, 1,0,20'h00000,0,3));
      vq.push_back(mk(0,1,  5,0,0, 0,1,20'h00064,0,4));
      vq.push_back(mk(0,0,  0,1,0, 1,0,20'h00064,0,0));

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         rst4           = v.rst;
         bus4.valid_in  = v.vin;
         bus4.a         = v.a;
         bus4.flush     = v.fl;
         bus4.ready_out = v.ro;
         tick();
         chk("ready_in",  i, 32'(bus4.ready_in),  32'(v.e_rdy));
         chk("valid_out", i, 32'(bus4.valid_out), 32'(v.e_vo));
         chk("f",         i, 32'(bus4.f),         32'(v.e_f));
         chk("overflow",  i, 32'(bus4.overflow),  32'(v.e_ovf));
         chk("count",     i, 32'(bus4.count),     32'(v.e_cnt));
      end
      rst4 = 1'b0; bus4.valid_in = 1'b0; bus4.flush = 1'b0; bus4.ready_out = 1'b0;

      // VEC_LEN=20, 255 x20: saturates on sample 17
      rst20 = 1'b1;
      tick();
      chk("v20_rst_count", 0, 32'(bus20.count),    32'd0);
      chk("v20_rst_ovf",   0, 32'(bus20.overflow), 32'd0);
      chk("v20_rst_rdy",   0, 32'(bus20.ready_in), 32'd1);
      rst20 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         bus20.valid_in = 1'b1;
         bus20.a        = 8'd255;
         tick();
         eovf = (k >= 17);
         chk("v20_ovf",   k, 32'(bus20.overflow),  32'(eovf));
         chk("v20_count", k, 32'(bus20.count),     32'(k));
         chk("v20_vout",  k, 32'(bus20.valid_out), 32'(k == 20));
      end
      ef = 20'hFFFFF;
      chk("v20_f", 20, 32'(bus20.f), 32'(ef));
      bus20.a = 8'd3;
      tick();
      chk("v20_hold_vout", 21, 32'(bus20.valid_out), 32'd1);
      chk("v20_hold_ovf",  21, 32'(bus20.overflow),  32'd1);
      chk("v20_hold_f",    21, 32'(bus20.f),         32'(ef));
      bus20.valid_in  = 1'b0;
      bus20.ready_out = 1'b1;
      tick();
      chk("v20_hs_vout",  22, 32'(bus20.valid_out), 32'd0);
      chk("v20_hs_ovf",   22, 32'(bus20.overflow),  32'd0);
      chk("v20_hs_count", 22, 32'(bus20.count),     32'd0);
      chk("v20_hs_rdy",   22, 32'(bus20.ready_in),  32'd1);
      bus20.ready_out = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
